// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, registered response pulse.
// Optional LSU_SPLIT_EN turns misaligned half/word accesses into byte sequences.
module load_store_unit #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_base,
  input  logic [11:0] req_offset,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [11:0] mem_offset,
  output logic [31:0] mem_value,
  output logic [2:0]  mem_funct3,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_SPLIT,
    S_DRAIN, S_RESP, S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_base;
  logic [11:0] r_off;
  logic [31:0] r_wdata;
  logic [31:0] ea_c;
  logic        legal_c;
  logic        mis_c;
  logic        accept;

  assign accept    = (state_q == S_IDLE) && req_valid;
  assign req_ready = (state_q == S_IDLE) && rst_n;
  assign ea_c      = req_base + {{20{req_offset[11]}}, req_offset};

  always_comb begin
    legal_c = 1'b0;
    if (req_we)
      legal_c = req_funct3 inside {3'd0, 3'd1, 3'd2};
    else
      legal_c = req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  end

  assign mis_c = ((req_funct3[1:0] == 2'b01) && ea_c[0])
              || ((req_funct3[1:0] == 2'b10) && (ea_c[1:0] != 2'b00));

  function automatic logic [31:0] ext_load(
    input logic [2:0]  f3,
    input logic [31:0] a
  );
    logic [31:0] r;
    r = a;
    if (f3 == 3'd1) r = {{16{a[15]}}, a[15:0]};
    if (f3 == 3'd5) r = {16'h0, a[15:0]};
    return r;
  endfunction

`ifdef LSU_SPLIT_EN
  logic [31:0] r_ea;
  logic [31:0] asm_q, asm_d;
  logic [1:0]  n_last;
  logic        split_rd;
  logic        drain_done;
  logic [MEM_LATENCY-1:0] sh_v;
  logic [1:0]  sh_k [MEM_LATENCY];
  localparam logic [MEM_LATENCY-1:0] TAIL =
    (MEM_LATENCY)'(1) << (MEM_LATENCY - 1);

  assign n_last     = (r_f3[1:0] == 2'b01) ? 2'd1 : 2'd3;
  assign split_rd   = (state_q == S_SPLIT) && !r_we;
  assign drain_done = (sh_v & ~TAIL) == '0;

  always_comb begin
    asm_d = asm_q;
    if (sh_v[MEM_LATENCY-1])
      asm_d[{sh_k[MEM_LATENCY-1], 3'b000} +: 8] = mem_data[7:0];
  end

  // byte reads return in order; tag each with its index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_v  <= '0;
      asm_q <= '0;
      r_ea  <= '0;
      for (int i = 0; i < MEM_LATENCY; i++)
        sh_k[i] <= '0;
    end else begin
      sh_v[0] <= split_rd;
      sh_k[0] <= cnt_q;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        sh_v[i] <= sh_v[i-1];
        sh_k[i] <= sh_k[i-1];
      end
      asm_q <= accept ? '0 : asm_d;
      if (accept) r_ea <= ea_c;
    end
  end
`else
  logic lint_unused;
  assign lint_unused = ^ea_c[31:2];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (!legal_c)
            state_d = S_ERR;
          else if (mis_c)
`ifdef LSU_SPLIT_EN
            state_d = S_SPLIT;
`else
            state_d = S_ERR;
`endif
          else
            state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = r_we ? S_RESP : S_WAIT;
      S_WAIT:
        if (cnt_q == 2'(MEM_LATENCY - 1))
          state_d = S_RESP;
`ifdef LSU_SPLIT_EN
      S_SPLIT:
        if (cnt_q == n_last)
          state_d = r_we ? S_RESP : S_DRAIN;
      S_DRAIN:
        if (drain_done)
          state_d = S_RESP;
`endif
      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_addr   = '0;
    mem_offset = '0;
    mem_value  = '0;
    mem_funct3 = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    if (state_q == S_ISSUE) begin
      mem_addr   = r_base;
      mem_offset = r_off;
      mem_value  = r_wdata;
      mem_funct3 = r_f3;
      mem_read   = !r_we;
      mem_write  = r_we;
    end
`ifdef LSU_SPLIT_EN
    if (state_q == S_SPLIT) begin
      mem_addr   = r_ea;
      mem_offset = {10'h0, cnt_q};
      mem_value  = {24'h0, r_wdata[{cnt_q, 3'b000} +: 8]};
      mem_funct3 = r_we ? 3'd0 : 3'd4;
      mem_read   = !r_we;
      mem_write  = r_we;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      r_we       <= 1'b0;
      r_f3       <= '0;
      r_base     <= '0;
      r_off      <= '0;
      r_wdata    <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      cnt_q <= (state_d != state_q) ? 2'd0 : cnt_q + 2'd1;
      if (accept) begin
        r_we    <= req_we;
        r_f3    <= req_funct3;
        r_base  <= req_base;
        r_off   <= req_offset;
        r_wdata <= req_wdata;
      end
      resp_valid <= (state_d == S_RESP) || (state_d == S_ERR);
      resp_err   <= (state_d == S_ERR);
      resp_rdata <= '0;
      if (state_q == S_WAIT && state_d == S_RESP)
        resp_rdata <= mem_data;
`ifdef LSU_SPLIT_EN
      if (state_q == S_DRAIN && state_d == S_RESP)
        resp_rdata <= ext_load(r_f3, asm_d);
`endif
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a 64-byte registered memory.
// Works with and without LSU_SPLIT_EN.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_base = '0;
  logic [11:0] req_offset = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [11:0] mem_offset;
  logic [31:0] mem_value;
  logic [2:0]  mem_funct3;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_data = '0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3),
    .req_base(req_base), .req_offset(req_offset),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_offset(mem_offset),
    .mem_value(mem_value), .mem_funct3(mem_funct3),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_data(mem_data)
  );

  logic [7:0] mem [64];
  logic       inited = 1'b0;

  function automatic logic [31:0] rd_model(input logic [5:0] a, input logic [2:0] f3);
    logic [31:0] w;
    w = {mem[6'(a+3)], mem[6'(a+2)], mem[6'(a+1)], mem[a]};
    case (f3)
      3'd0: return {{24{w[7]}}, w[7:0]};
      3'd1: return {{16{w[15]}}, w[15:0]};
      3'd4: return {24'h0, w[7:0]};
      3'd5: return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [5:0] a;
    a = 6'(mem_addr + {{20{mem_offset[11]}}, mem_offset});
    if (!inited) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
      mem[8]  <= 8'h80; mem[9]  <= 8'h7F;
      mem[10] <= 8'h01; mem[11] <= 8'hFE;
      mem[20] <= 8'h11; mem[21] <= 8'h22;
      mem[22] <= 8'h33; mem[23] <= 8'h44;
      inited  <= 1'b1;
      mem_data <= '0;
    end else begin
      if (mem_write) begin
        mem[a] <= mem_value[7:0];
        if (mem_funct3[1:0] != 2'b00) mem[6'(a+1)] <= mem_value[15:8];
        if (mem_funct3[1:0] == 2'b10) begin
          mem[6'(a+2)] <= mem_value[23:16];
          mem[6'(a+3)] <= mem_value[31:24];
        end
      end
      mem_data <= mem_read ? rd_model(a, mem_funct3) : 32'h0;
    end
  end

  int ncmp = 0;
  int nfail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [31:0] o_rd;
  logic        o_err;
  int          o_lat, o_nrd, o_nwr, o_rcyc;
  logic [11:0] o_off [4];
  logic [1:0]  o_after;

  task automatic run(input logic we, input logic [2:0] f3,
                     input logic [31:0] base, input logic [11:0] off,
                     input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_base = base; req_offset = off; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    o_lat = 0; o_nrd = 0; o_nwr = 0; o_rcyc = 0;
    o_rd = 'x; o_err = 1'bx;
    for (int i = 0; i < 4; i++) o_off[i] = 'x;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mem_read) begin
        if (o_nrd < 4) o_off[o_nrd] = mem_offset;
        if (o_nrd == 0) o_rcyc = c;
        o_nrd++;
      end
      if (mem_write) o_nwr++;
      if (resp_valid) begin
        o_lat = c; o_rd = resp_rdata; o_err = resp_err;
        break;
      end
    end
    @(negedge clk);
    o_after = {resp_valid, req_ready};
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_rvalid", 32'(resp_valid), 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_err", 32'(resp_err), 0);
    chk("rst_strobes", {30'h0, mem_read, mem_write}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(req_ready), 1);

    run(1'b0, 3'd2, 32'd8, 12'h000, 0);
    chk("lw_rdata", o_rd, 32'hFE017F80);
    chk("lw_err", 32'(o_err), 0);
    chk("lw_lat", 32'(o_lat), 3);
    chk("lw_rdcyc", 32'(o_rcyc), 1);
    chk("lw_nrd", 32'(o_nrd), 1);
    chk("lw_after", 32'(o_after), 32'd1);

    run(1'b0, 3'd0, 32'd12, 12'hFFC, 0);
    chk("lb_rdata", o_rd, 32'hFFFFFF80);
    run(1'b0, 3'd4, 32'd12, 12'hFFC, 0);
    chk("lbu_rdata", o_rd, 32'h00000080);

    run(1'b1, 3'd2, 32'd16, 12'h000, 32'hDEADBEEF);
    chk("sw_lat", 32'(o_lat), 2);
    chk("sw_nwr", 32'(o_nwr), 1);
    chk("sw_rdata", o_rd, 0);
    chk("sw_err", 32'(o_err), 0);
    run(1'b0, 3'd5, 32'd18, 12'h000, 0);
    chk("lhu_rdata", o_rd, 32'h0000DEAD);
    run(1'b0, 3'd1, 32'd18, 12'h000, 0);
    chk("lh_rdata", o_rd, 32'hFFFFDEAD);

    run(1'b0, 3'd1, 32'd9, 12'h000, 0);
`ifdef LSU_SPLIT_EN
    chk("mis_lh_rdata", o_rd, 32'h0000017F);
    chk("mis_lh_err", 32'(o_err), 0);
    chk("mis_lh_lat", 32'(o_lat), 4);
    chk("mis_lh_nrd", 32'(o_nrd), 2);
    chk("mis_lh_off0", 32'(o_off[0]), 0);
    chk("mis_lh_off1", 32'(o_off[1]), 1);
`else
    chk("mis_lh_err", 32'(o_err), 1);
    chk("mis_lh_rdata", o_rd, 0);
    chk("mis_lh_nrd", 32'(o_nrd), 0);
    chk("mis_lh_lat", 32'(o_lat), 1);
`endif

    run(1'b0, 3'd2, 32'd9, 12'h000, 0);
`ifdef LSU_SPLIT_EN
    chk("mis_lw_rdata", o_rd, 32'h00FE017F);
    chk("mis_lw_lat", 32'(o_lat), 6);
`else
    chk("mis_lw_err", 32'(o_err), 1);
`endif

    run(1'b1, 3'd1, 32'd17, 12'h000, 32'h0000CAFE);
`ifdef LSU_SPLIT_EN
    chk("mis_sh_lat", 32'(o_lat), 3);
    chk("mis_sh_nwr", 32'(o_nwr), 2);
    run(1'b0, 3'd2, 32'd16, 12'h000, 0);
    chk("mis_sh_result", o_rd, 32'hDECAFEEF);
`else
    chk("mis_sh_err", 32'(o_err), 1);
    chk("mis_sh_nwr", 32'(o_nwr), 0);
    run(1'b0, 3'd2, 32'd16, 12'h000, 0);
    chk("mis_sh_result", o_rd, 32'hDEADBEEF);
`endif

    run(1'b0, 3'd3, 32'd8, 12'h000, 0);
    chk("ill_ld_err", 32'(o_err), 1);
    chk("ill_ld_lat", 32'(o_lat), 1);
    chk("ill_ld_rdata", o_rd, 0);
    chk("ill_ld_nrd", 32'(o_nrd), 0);
    chk("ill_ld_after", 32'(o_after), 32'd1);
    run(1'b1, 3'd4, 32'd8, 12'h000, 32'h12345678);
    chk("ill_st_err", 32'(o_err), 1);
    chk("ill_st_lat", 32'(o_lat), 1);
    chk("ill_st_nwr", 32'(o_nwr), 0);

    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
    req_base = 32'd20; req_offset = 12'h000; req_wdata = 32'hA5A5A5A5;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("abort_wr_before", 32'(mem_write), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_wr_drop", 32'(mem_write), 0);
    chk("abort_ready", 32'(req_ready), 0);
    @(negedge clk);
    chk("abort_rvalid", 32'(resp_valid), 0);
    chk("abort_mem", {mem[23], mem[22], mem[21], mem[20]}, 32'h44332211);
    rst_n = 1'b1;
    run(1'b0, 3'd2, 32'd20, 12'h000, 0);
    chk("abort_readback", o_rd, 32'h44332211);
    chk("abort_rb_lat", 32'(o_lat), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
